// File: rtl/prescaled_toggle_bank.sv
// Bank of independent toggle flip-flops. Each channel flips once every (divide+1)
// accepted requests, with shared synchronous clear/load and a registered change pulse.

module prescaled_toggle_cell #(
    parameter int   DIVIDE_WIDTH = 4,
    parameter logic RESET_BIT    = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    loadbit,
    input  logic                    toggle,
    input  logic [DIVIDE_WIDTH-1:0] divide,
    output logic                    q,
    output logic                    chg
);
    logic [DIVIDE_WIDTH-1:0] cnt;

    // >= rather than == so a divide lowered below the current count flips on the next request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q   <= RESET_BIT;
            cnt <= '0;
            chg <= 1'b0;
        end else if (clear) begin
            q   <= RESET_BIT;
            cnt <= '0;
            chg <= q ^ RESET_BIT;
        end else if (load) begin
            q   <= loadbit;
            cnt <= '0;
            chg <= q ^ loadbit;
        end else if (toggle) begin
            if (cnt >= divide) begin
                q   <= ~q;
                cnt <= '0;
                chg <= 1'b1;
            end else begin
                cnt <= cnt + DIVIDE_WIDTH'(1);
                chg <= 1'b0;
            end
        end else begin
            chg <= 1'b0;
        end
    end
endmodule

module prescaled_toggle_bank #(
    parameter int               WIDTH        = 8,
    parameter int               DIVIDE_WIDTH = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}}
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic [WIDTH-1:0]        loadData,
    input  logic [WIDTH-1:0]        toggle,
    input  logic [DIVIDE_WIDTH-1:0] divide,
    output logic [WIDTH-1:0]        dataOut,
    output logic [WIDTH-1:0]        changed
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        prescaled_toggle_cell #(
            .DIVIDE_WIDTH (DIVIDE_WIDTH),
            .RESET_BIT    (RESET_VALUE[i])
        ) u_cell (
            .clock   (clock),
            .reset   (reset),
            .clear   (clear),
            .load    (load),
            .loadbit (loadData[i]),
            .toggle  (toggle[i]),
            .divide  (divide),
            .q       (dataOut[i]),
            .chg     (changed[i])
        );
    end
endmodule

// File: tb/tb_prescaled_toggle_bank.sv
// Scoreboard bench: stimulus pushes hand-computed expected outputs, a monitor
// pops and compares one entry after each rising edge.

module tb_prescaled_toggle_bank;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] loadData = '0;
    logic [7:0] toggle = '0;
    logic [3:0] divide = '0;
    logic [7:0] dataOut, changed;

    typedef struct {
        logic [7:0] d;
        logic [7:0] c;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails = 0;

    prescaled_toggle_bank #(.WIDTH(8), .DIVIDE_WIDTH(4), .RESET_VALUE(8'h00)) dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .load     (load),
        .loadData (loadData),
        .toggle   (toggle),
        .divide   (divide),
        .dataOut  (dataOut),
        .changed  (changed)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: outputs are registered, so each pushed entry is due right after the next edge
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".dataOut"}, dataOut, e.d);
            check({e.name, ".changed"}, changed, e.c);
        end
    end

    task automatic step(input string name, input logic clr, input logic ld,
                        input logic [7:0] ldd, input logic [7:0] tg, input logic [3:0] dv,
                        input logic [7:0] ed, input logic [7:0] ec);
        exp_t e;
        @(negedge clock);
        clear = clr; load = ld; loadData = ldd; toggle = tg; divide = dv;
        e.d = ed; e.c = ec; e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        #12;
        check("reset.dataOut", dataOut, 8'h00);
        check("reset.changed", changed, 8'h00);
        @(negedge clock);
        reset = 1'b0;

        // plain T flip-flop
        step("plain1", 0, 0, 8'h00, 8'h01, 4'd0, 8'h01, 8'h01);
        step("plain2", 0, 0, 8'h00, 8'h01, 4'd0, 8'h00, 8'h01);
        step("plain3", 0, 0, 8'h00, 8'h01, 4'd0, 8'h01, 8'h01);
        step("plain4", 0, 0, 8'h00, 8'h01, 4'd0, 8'h00, 8'h01);

        // prescale by 4
        step("pre1", 0, 0, 8'h00, 8'hFF, 4'd3, 8'h00, 8'h00);
        step("pre2", 0, 0, 8'h00, 8'hFF, 4'd3, 8'h00, 8'h00);
        step("pre3", 0, 0, 8'h00, 8'hFF, 4'd3, 8'h00, 8'h00);
        step("pre4", 0, 0, 8'h00, 8'hFF, 4'd3, 8'hFF, 8'hFF);
        step("pre5", 0, 0, 8'h00, 8'hFF, 4'd3, 8'hFF, 8'h00);
        step("pre6", 0, 0, 8'h00, 8'hFF, 4'd3, 8'hFF, 8'h00);
        step("pre7", 0, 0, 8'h00, 8'hFF, 4'd3, 8'hFF, 8'h00);
        step("pre8", 0, 0, 8'h00, 8'hFF, 4'd3, 8'h00, 8'hFF);

        // priority clear > load > toggle
        step("prio_load0F", 0, 1, 8'h0F, 8'h00, 4'd3, 8'h0F, 8'h0F);
        step("prio_clear",  1, 1, 8'hA5, 8'hFF, 4'd3, 8'h00, 8'h0F);
        step("prio_load",   0, 1, 8'hA5, 8'hFF, 4'd3, 8'hA5, 8'hA5);
        step("prio_hold",   0, 0, 8'h00, 8'h00, 4'd3, 8'hA5, 8'h00);

        // divide lowered mid-count on channel 2
        step("low_clear", 1, 0, 8'h00, 8'h00, 4'd7, 8'h00, 8'hA5);
        for (int i = 0; i < 5; i++)
            step("low_cnt", 0, 0, 8'h00, 8'h04, 4'd7, 8'h00, 8'h00);
        step("low_flip", 0, 0, 8'h00, 8'h04, 4'd2, 8'h04, 8'h04);
        step("low_hold", 0, 0, 8'h00, 8'h00, 4'd2, 8'h04, 8'h00);

        // counts part-way, then a flip on ch0 so changed is high when reset hits
        step("ar_cnt1", 0, 0, 8'h00, 8'hFF, 4'd5, 8'h04, 8'h00);
        step("ar_cnt2", 0, 0, 8'h00, 8'hFF, 4'd5, 8'h04, 8'h00);
        step("ar_flip", 0, 0, 8'h00, 8'h01, 4'd0, 8'h05, 8'h01);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("areset.dataOut", dataOut, 8'h00);
        check("areset.changed", changed, 8'h00);
        @(negedge clock);
        toggle = 8'h00;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++)
            step("ar_post", 0, 0, 8'h00, 8'hFF, 4'd5, 8'h00, 8'h00);
        step("ar_first", 0, 0, 8'h00, 8'hFF, 4'd5, 8'hFF, 8'hFF);

        // independence with alternating channel masks
        step("ind_clear", 1, 0, 8'h00, 8'h00, 4'd1, 8'h00, 8'hFF);
        step("ind1", 0, 0, 8'h00, 8'h55, 4'd1, 8'h00, 8'h00);
        step("ind2", 0, 0, 8'h00, 8'hAA, 4'd1, 8'h00, 8'h00);
        step("ind3", 0, 0, 8'h00, 8'h55, 4'd1, 8'h55, 8'h55);
        step("ind4", 0, 0, 8'h00, 8'hAA, 4'd1, 8'hFF, 8'hAA);
        step("ind_hold", 0, 0, 8'h00, 8'h00, 4'd1, 8'hFF, 8'h00);

        // maximum divide: 16 requests per flip
        step("max_clear", 1, 0, 8'h00, 8'h00, 4'd15, 8'h00, 8'hFF);
        for (int i = 0; i < 15; i++)
            step("max_cnt", 0, 0, 8'h00, 8'h80, 4'd15, 8'h00, 8'h00);
        step("max_flip", 0, 0, 8'h00, 8'h80, 4'd15, 8'h80, 8'h80);

        @(negedge clock);
        toggle = 8'h00;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/prescaled_toggle_bank.md
# prescaled_toggle_bank

Parametrised bank of independent toggle flip-flops. Each channel flips its output once every (divide+1) accepted toggle requests, so one block serves both as a plain T flip-flop (divide = 0) and as a per-channel event prescaler. It adds synchronous clear, parallel load and a registered per-channel change-pulse output. It sits in the basic synchronous logic library as the general-purpose successor to the single-bit toggle flip-flop.

## Interface
Parameters:
- WIDTH, 8: number of independent channels; legal range is 1 or more.
- DIVIDE_WIDTH, 4: width of the divide input and of each per-channel prescale counter; legal range is 1 or more.
- RESET_VALUE, {WIDTH{1'b0}}: value driven onto dataOut by reset and by clear.

Ports:
- clock  input  1  Core clock; all state updates on the rising edge.
- reset  input  1  Asynchronous, active-high reset.
- clear  input  1  Synchronous clear of all channels.
- load  input  1  Synchronous parallel load of dataOut from loadData.
- loadData  input  WIDTH  Value taken by dataOut when load is high.
- toggle  input  WIDTH  Per-channel toggle request, sampled each clock.
- divide  input  DIVIDE_WIDTH  Shared prescale threshold. A channel flips on every (divide+1)th request.
- dataOut  output  WIDTH  Registered channel outputs.
- changed  output  WIDTH  Registered one-cycle pulse per channel, high in the first cycle a new dataOut value is visible.

## Operation
- State per channel i: dataOut[i] plus a prescale counter cnt[i] of DIVIDE_WIDTH bits.
- Reset, asynchronous: dataOut = RESET_VALUE, every cnt = 0, changed = 0. Reset takes effect immediately, mid-count or mid-load, and no pulse is emitted.
- Each rising edge applies exactly one action, in this priority order: clear > load > toggle > hold.
- Clear:
  - dataOut <= RESET_VALUE and every cnt <= 0.
  - changed <= dataOut ^ RESET_VALUE.
  - load and toggle are ignored in the same cycle.
- Load:
  - dataOut <= loadData and every cnt <= 0.
  - changed <= dataOut ^ loadData.
  - toggle is ignored in the same cycle.
- Toggle, evaluated independently per channel when toggle[i] = 1:
  - If cnt[i] >= divide: dataOut[i] <= ~dataOut[i], cnt[i] <= 0, changed[i] <= 1.
  - Otherwise: cnt[i] <= cnt[i] + 1, changed[i] <= 0.
- Hold, when toggle[i] = 0: dataOut[i] and cnt[i] are unchanged and changed[i] <= 0.
- The comparison uses >=. If divide is lowered below a channel's current count, that channel's next request flips it immediately.
- The counter cannot overflow: its maximum value is divide, which is at most 2^DIVIDE_WIDTH − 1, and it resets to 0 on each flip.
- divide is sampled every cycle and is not latched. Changing it mid-count applies from the next request onward.
- divide = 0 gives plain T flip-flop behaviour: every request flips the channel.
- Channels never interact except through the shared clear, load and divide inputs.

## Timing
- All outputs come straight from flops; there is no combinational path from any input to any output.
- Latency is 1 cycle: a request sampled at edge N is reflected in dataOut and changed after edge N.
- changed is high for exactly one cycle per flip. Back-to-back flips, with divide = 0 and toggle held high, give changed high on every cycle while dataOut alternates.
- Asserting toggle continuously counts one request per clock.
- Reset deassertion is synchronised externally. The first functional edge is the first rising clock edge after reset falls.

## Test plan
- **Plain toggle:** WIDTH = 8, divide = 0. Hold toggle = 8'h01 for 4 cycles. dataOut[0] must read 1, 0, 1, 0; changed[0] must be high on all 4 cycles; all other bits stay 0.
- **Prescale:** divide = 3. Hold toggle = 8'hFF for 8 cycles. dataOut must go to 8'hFF after the 4th request and back to 8'h00 after the 8th; changed = 8'hFF only on those 2 cycles.
- **Priority:** first put dataOut at 8'h0F. Then, in one cycle, assert clear, load = 1 with loadData = 8'hA5, and toggle = 8'hFF. The result must be dataOut = 8'h00 (RESET_VALUE) and changed = 8'h0F. The next cycle, load with 8'hA5 plus toggle: dataOut = 8'hA5, changed = 8'hA5.
- **Divide lowered mid-count:** divide = 7; issue 5 requests on channel 2. Set divide = 2; the next request must flip dataOut[2], and changed[2] must pulse once.
- **Asynchronous reset mid-operation:** with divide = 5 and counts part-way, assert reset between clock edges. dataOut must equal RESET_VALUE immediately and changed = 0. After release, 6 requests are needed for the first flip.
- **Independence:** divide = 1, toggle alternating 8'h55 and 8'hAA for 4 cycles. Every channel must flip exactly once, with no cross-channel effects.
